// File: rtl/ceespu_fetch.sv
// ceespu instruction-fetch stage: issues the PC to the 1-cycle instruction memory and
// collects {instr, pc} in a 2-entry skid FIFO for decode, generating the PC-stage stall.
module ceespu_fetch #(
    parameter int ADDR_W  = 14,
    parameter int INSTR_W = 32
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic [ADDR_W-1:0]  I_pc,
    input  logic               I_branch,
    input  logic               I_stall,
    output logic [ADDR_W-1:0]  O_imem_addr,
    output logic               O_imem_en,
    input  logic [INSTR_W-1:0] I_imem_data,
    output logic [INSTR_W-1:0] O_instr,
    output logic [ADDR_W-1:0]  O_instr_pc,
    output logic               O_valid,
    output logic               O_stall_pc
);

    logic               started_q, started_d;
    logic               inflight_v_q, inflight_v_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic [1:0]         count_q, count_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [INSTR_W-1:0] fifo_instr_q [2];
    logic [ADDR_W-1:0]  fifo_pc_q    [2];

    logic               pop;
    logic               push;
    logic               issue;
    logic [2:0]         occupancy;

    // Occupancy after this cycle's pop, counting the word already in flight.
    assign O_valid   = (count_q != 2'd0);
    assign pop       = O_valid & ~I_stall & ~I_branch;
    assign push      = inflight_v_q & ~I_branch;
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_v_q} - {2'b00, pop};
    assign issue     = started_q & ~I_branch & (occupancy <= 3'd1);

    assign O_imem_addr = I_pc;
    assign O_imem_en   = issue;
    assign O_stall_pc  = started_q & ~I_branch & ~issue;

    assign O_instr    = fifo_instr_q[rd_ptr_q];
    assign O_instr_pc = fifo_pc_q[rd_ptr_q];

    // NOTE: every next-state signal gets a default at the top so no path leaves it unassigned (no latch).
    always_comb begin
        started_d     = 1'b1;
        inflight_v_d  = issue;
        inflight_pc_d = issue ? I_pc : inflight_pc_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        if (I_branch) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            started_q     <= 1'b0;
            inflight_v_q  <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= 2'd0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
        end else begin
            started_q     <= started_d;
            inflight_v_q  <= inflight_v_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // NOTE: the FIFO storage is reset because O_instr/O_instr_pc read it directly and must be 0 in reset.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else if (push) begin
            fifo_instr_q[wr_ptr_q] <= I_imem_data;
            fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

    // The issue rule must never let a returning word land in a full FIFO.
    a_no_push_when_full : assert property (
        @(posedge I_clk) disable iff (I_rst) !(push && count_q == 2'd2)
    );

endmodule

// File: tb/tb_ceespu_fetch.sv
// Self-checking bench for ceespu_fetch: models the PC stage and instruction memory, and
// compares the DUT every cycle against a queue-based reference of the fetch behaviour.
module tb_ceespu_fetch;

    localparam int ADDR_W  = 14;
    localparam int INSTR_W = 32;

    logic               I_clk;
    logic               I_rst;
    logic [ADDR_W-1:0]  I_pc;
    logic               I_branch;
    logic               I_stall;
    logic [ADDR_W-1:0]  O_imem_addr;
    logic               O_imem_en;
    logic [INSTR_W-1:0] I_imem_data;
    logic [INSTR_W-1:0] O_instr;
    logic [ADDR_W-1:0]  O_instr_pc;
    logic               O_valid;
    logic               O_stall_pc;

    int checks = 0;
    int errors = 0;

    // Reference model: fetch started flag, one in-flight request, FIFO of PCs in order.
    bit                m_started;
    bit                m_inflight;
    logic [ADDR_W-1:0] m_inflight_pc;
    logic [ADDR_W-1:0] m_q[$];

    logic [ADDR_W-1:0] delivered[$];

    logic               s_en;
    logic               s_stallpc;
    logic               s_valid;
    logic [INSTR_W-1:0] s_instr;
    logic [ADDR_W-1:0]  s_instr_pc;
    logic [ADDR_W-1:0]  s_pc;
    logic [ADDR_W-1:0]  s_addr;

    ceespu_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .I_clk       (I_clk),
        .I_rst       (I_rst),
        .I_pc        (I_pc),
        .I_branch    (I_branch),
        .I_stall     (I_stall),
        .O_imem_addr (O_imem_addr),
        .O_imem_en   (O_imem_en),
        .I_imem_data (I_imem_data),
        .O_instr     (O_instr),
        .O_instr_pc  (O_instr_pc),
        .O_valid     (O_valid),
        .O_stall_pc  (O_stall_pc)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    function automatic logic [INSTR_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
        return 32'hA000_0000 + {18'h0, a};
    endfunction

    task automatic reset_model();
        m_started     = 1'b0;
        m_inflight    = 1'b0;
        m_inflight_pc = '0;
        m_q.delete();
        I_pc          = 14'h3FFF;
        I_imem_data   = '0;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input logic stall, input logic branch, input logic [ADDR_W-1:0] target);
        logic valid_m, pop_m, issue_m, stallpc_m;
        int   occ;
        I_stall  = stall;
        I_branch = branch;
        #1;
        valid_m   = (m_q.size() != 0);
        pop_m     = valid_m && !stall && !branch;
        occ       = m_q.size() + (m_inflight ? 1 : 0) - (pop_m ? 1 : 0);
        issue_m   = m_started && !branch && (occ <= 1);
        stallpc_m = m_started && !branch && !issue_m;

        checks++;
        if (O_imem_en !== issue_m) begin
            errors++;
            $display("FAIL imem_en t=%0t: got %b want %b", $time, O_imem_en, issue_m);
        end
        checks++;
        if (O_stall_pc !== stallpc_m) begin
            errors++;
            $display("FAIL stall_pc t=%0t: got %b want %b", $time, O_stall_pc, stallpc_m);
        end
        checks++;
        if (O_imem_addr !== I_pc) begin
            errors++;
            $display("FAIL imem_addr t=%0t: got %h want %h", $time, O_imem_addr, I_pc);
        end
        if (!branch) begin
            checks++;
            if (O_valid !== valid_m) begin
                errors++;
                $display("FAIL valid t=%0t: got %b want %b", $time, O_valid, valid_m);
            end
        end
        if (valid_m && !branch) begin
            checks++;
            if (O_instr_pc !== m_q[0] || O_instr !== mem_f(m_q[0])) begin
                errors++;
                $display("FAIL head t=%0t: got pc %h instr %h want pc %h instr %h",
                         $time, O_instr_pc, O_instr, m_q[0], mem_f(m_q[0]));
            end
        end

        s_en       = O_imem_en;
        s_stallpc  = O_stall_pc;
        s_valid    = O_valid;
        s_instr    = O_instr;
        s_instr_pc = O_instr_pc;
        s_pc       = I_pc;
        s_addr     = O_imem_addr;
        if (O_valid && !stall && !branch) delivered.push_back(O_instr_pc);

        @(posedge I_clk);
        #1;
        m_started = 1'b1;
        if (branch) begin
            m_q.delete();
            m_inflight = 1'b0;
        end else begin
            if (m_inflight) m_q.push_back(m_inflight_pc);
            if (pop_m) void'(m_q.pop_front());
            m_inflight = issue_m;
            if (issue_m) m_inflight_pc = s_pc;
        end
        // Environment: synchronous memory and the upstream PC stage.
        if (s_en) I_imem_data = mem_f(s_addr);
        if (branch)          I_pc = target;
        else if (!s_stallpc) I_pc = I_pc + 14'd1;
        @(negedge I_clk);
    endtask

    task automatic test_reset_release(input string tag);
        int first_issue;
        int first_valid;
        first_issue = -1;
        first_valid = -1;
        delivered.delete();
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, '0);
            if (i == 0) begin
                checks++;
                if (s_pc !== 14'h3FFF || s_en !== 1'b0) begin
                    errors++;
                    $display("FAIL %s no_issue_3fff: got pc %h en %b want pc 3fff en 0", tag, s_pc, s_en);
                end
            end
            if (s_en && first_issue < 0) begin
                first_issue = i;
                checks++;
                if (s_pc !== 14'h0000) begin
                    errors++;
                    $display("FAIL %s first_issue_pc: got %h want 0000", tag, s_pc);
                end
            end
            if (s_valid && first_valid < 0) first_valid = i;
        end
        checks++;
        if (first_issue != 1) begin
            errors++;
            $display("FAIL %s first_issue_cycle: got %0d want 1", tag, first_issue);
        end
        checks++;
        if (first_valid != 3) begin
            errors++;
            $display("FAIL %s first_valid_cycle: got %0d want 3", tag, first_valid);
        end
        checks++;
        if (delivered.size() != 17) begin
            errors++;
            $display("FAIL %s delivered_count: got %0d want 17", tag, delivered.size());
        end
        for (int k = 0; k < delivered.size(); k++) begin
            checks++;
            if (delivered[k] !== 14'(k)) begin
                errors++;
                $display("FAIL %s delivered_seq[%0d]: got %h want %h", tag, k, delivered[k], 14'(k));
            end
        end
    endtask

    task automatic test_reset();
        I_rst    = 1'b1;
        I_stall  = 1'b0;
        I_branch = 1'b0;
        reset_model();
        #2;
        checks++;
        if (O_valid !== 1'b0 || O_imem_en !== 1'b0 || O_stall_pc !== 1'b0 ||
            O_instr !== '0 || O_instr_pc !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid %b en %b stall_pc %b instr %h pc %h want all 0",
                     O_valid, O_imem_en, O_stall_pc, O_instr, O_instr_pc);
        end
        @(negedge I_clk);
        I_rst = 1'b0;
        test_reset_release("startup");
    endtask

    task automatic test_stall();
        logic [INSTR_W-1:0] held;
        logic [ADDR_W-1:0]  held_pc;
        held    = '0;
        held_pc = '0;
        delivered.delete();
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, '0);
            checks++;
            if (s_stallpc !== 1'b1) begin
                errors++;
                $display("FAIL stall_pc_follow[%0d]: got %b want 1", i, s_stallpc);
            end
            if (i == 0) begin
                held    = s_instr;
                held_pc = s_instr_pc;
            end else begin
                checks++;
                if (s_instr !== held || s_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold[%0d]: got instr %h valid %b want %h 1", i, s_instr, s_valid, held);
                end
            end
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
        checks++;
        if (delivered.size() != 8) begin
            errors++;
            $display("FAIL stall_count: got %0d want 8", delivered.size());
        end else begin
            checks++;
            if (delivered[2] !== held_pc) begin
                errors++;
                $display("FAIL stall_head_after_release: got %h want %h", delivered[2], held_pc);
            end
            for (int k = 1; k < 8; k++) begin
                checks++;
                if (delivered[k] !== delivered[0] + 14'(k)) begin
                    errors++;
                    $display("FAIL stall_seq[%0d]: got %h want %h", k, delivered[k], delivered[0] + 14'(k));
                end
            end
        end
    endtask

    task automatic test_branch_full();
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 14'h0100);
        checks++;
        if (s_stallpc !== 1'b0) begin
            errors++;
            $display("FAIL bfull_stall_pc: got %b want 0", s_stallpc);
        end
        delivered.delete();
        step(1'b0, 1'b0, '0);
        checks++;
        if (s_valid !== 1'b0 || s_en !== 1'b1 || s_pc !== 14'h0100) begin
            errors++;
            $display("FAIL bfull_target_issue: got valid %b en %b pc %h want 0 1 0100", s_valid, s_en, s_pc);
        end
        step(1'b0, 1'b0, '0);
        checks++;
        if (s_valid !== 1'b0) begin
            errors++;
            $display("FAIL bfull_bubble: got valid %b want 0", s_valid);
        end
        step(1'b0, 1'b0, '0);
        checks++;
        if (s_valid !== 1'b1 || s_instr_pc !== 14'h0100 || s_instr !== 32'hA000_0100) begin
            errors++;
            $display("FAIL bfull_target_out: got valid %b pc %h instr %h want 1 0100 a0000100",
                     s_valid, s_instr_pc, s_instr);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
        checks++;
        if (delivered.size() != 4) begin
            errors++;
            $display("FAIL bfull_count: got %0d want 4", delivered.size());
        end
        for (int k = 0; k < delivered.size(); k++) begin
            checks++;
            if (delivered[k] !== 14'h0100 + 14'(k)) begin
                errors++;
                $display("FAIL bfull_seq[%0d]: got %h want %h", k, delivered[k], 14'h0100 + 14'(k));
            end
        end
    endtask

    task automatic test_branch_stall_inflight();
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 14'h0200);
        checks++;
        if (s_stallpc !== 1'b0 || s_en !== 1'b0) begin
            errors++;
            $display("FAIL bstall_flush_wins: got stall_pc %b en %b want 0 0", s_stallpc, s_en);
        end
        delivered.delete();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
        checks++;
        if (delivered.size() != 4 || delivered[0] !== 14'h0200 || delivered[3] !== 14'h0203) begin
            errors++;
            $display("FAIL bstall_seq: got n=%0d first %h want n=4 first 0200",
                     delivered.size(), (delivered.size() != 0) ? delivered[0] : 14'h0);
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b1, 14'h3FFF);
        delivered.delete();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
        checks++;
        if (delivered.size() != 4 || delivered[0] !== 14'h3FFF || delivered[1] !== 14'h0000) begin
            errors++;
            $display("FAIL wrap_seq: got n=%0d [0]=%h [1]=%h want n=4 3fff 0000", delivered.size(),
                     (delivered.size() > 0) ? delivered[0] : 14'h0, (delivered.size() > 1) ? delivered[1] : 14'h0);
        end
    endtask

    task automatic test_random();
        logic st, br;
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 99) < 30);
            br = ($urandom_range(0, 99) < 8);
            step(st, br, 14'($urandom));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        I_stall  = 1'b0;
        I_branch = 1'b0;
        #2;
        I_rst = 1'b1;
        #1;
        checks++;
        if (O_valid !== 1'b0 || O_imem_en !== 1'b0 || O_stall_pc !== 1'b0 ||
            O_instr !== '0 || O_instr_pc !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: got valid %b en %b stall_pc %b instr %h pc %h want all 0",
                     O_valid, O_imem_en, O_stall_pc, O_instr, O_instr_pc);
        end
        reset_model();
        @(posedge I_clk);
        @(negedge I_clk);
        I_rst = 1'b0;
        test_reset_release("after_async_reset");
    endtask

    initial begin
        test_reset();
        test_stall();
        test_branch_full();
        test_branch_stall_inflight();
        test_wrap();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ceespu_fetch.md
# ceespu_fetch

Instruction-fetch stage of the ceespu pipeline, placed directly downstream of the PC stage and upstream of decode. Each cycle it takes the current PC, issues it to the synchronous instruction memory (1-cycle read latency), and captures the returned word with its PC in a 2-entry skid FIFO presented to decode. It generates the back-pressure stall that holds the PC stage, and flushes all wrong-path state when a branch is taken.

## Interface
- ADDR_W, 14, PC / instruction-memory word-address width
- INSTR_W, 32, instruction width
- I_clk  in  1  clock; all state updates on rising edge
- I_rst  in  1  reset; asynchronous, active-high
- I_pc  in  ADDR_W  current PC from the PC stage
- I_branch  in  1  branch taken this cycle (same signal driving the PC stage); flush
- I_stall  in  1  decode cannot accept the head entry this cycle
- O_imem_addr  out  ADDR_W  instruction-memory address; combinationally equal to I_pc
- O_imem_en  out  1  read request issued this cycle
- I_imem_data  in  INSTR_W  read data, valid the cycle after the matching O_imem_en
- O_instr  out  INSTR_W  FIFO head instruction
- O_instr_pc  out  ADDR_W  PC of O_instr
- O_valid  out  1  FIFO non-empty
- O_stall_pc  out  1  hold PC stage; wire to the PC stage's stall input

## Operation
- State: started (1b), inflight_v (1b), inflight_pc, FIFO of 2 entries {instr, pc}, count 0..2, rd/wr pointers.
- Reset (async): started=0, inflight_v=0, count=0, pointers=0, FIFO storage and O_instr/O_instr_pc=0. Outputs during reset: O_valid=0, O_imem_en=0, O_stall_pc=0.
- started: set on the first clock edge after reset release. While started=0: no issue, O_stall_pc=0 (lets the PC advance from its reset value 0x3FFF to 0x0000; 0x3FFF is not fetched).
- pop = O_valid & !I_stall & !I_branch.
- issue = started & !I_branch & (count + inflight_v - pop <= 1).
- O_imem_en = issue; O_stall_pc = started & !I_branch & !issue.
- Edge, no branch: if inflight_v, push {I_imem_data, inflight_pc}; if pop, advance rd pointer; count updates with push/pop together; inflight_v<=issue, inflight_pc<=I_pc when issued.
- Issue rule guarantees a push never finds count==2; push into full FIFO is an assertion failure.
- Branch (I_branch=1): takes priority over stall and pop. At the edge: count=0, pointers=0, inflight_v=0 (returning data discarded), nothing issued. Next cycle I_pc holds the target and is issued normally.
- O_valid = (count != 0); O_instr/O_instr_pc = entry at rd pointer. Decode must ignore O_valid in a cycle where I_branch=1.
- PC width arithmetic: count/pointers are modular; PC values pass through unmodified (no increment here).

## Timing
- Issue at cycle t (O_imem_en=1, address A) -> data sampled at t+1 -> pushed at end of t+1 -> O_valid with O_instr_pc=A at t+2 if FIFO was empty.
- Steady state without stalls: one issue and one O_valid instruction per cycle, in PC order, count=1.
- I_stall rising in steady state (count=1, inflight_v=1): O_stall_pc=1 same cycle (combinational); PC holds; in-flight word lands, count=2; no loss, no duplication.
- I_stall falling with count=2: pop; count+inflight-pop=1 -> issue same cycle at the held PC.
- Async reset mid-operation: outputs clear immediately without a clock edge; first issue two edges after release (one bubble edge, then PC 0x0000).

## Test plan
- Reset release, memory returns {18'h0, addr}+32'hA000_0000, no stall: I_pc 0x3FFF not issued; O_imem_en=1 first with I_pc=0x0000; O_valid two cycles later with O_instr_pc 0,1,2,... every cycle, data matching.
- Steady stream, I_stall high 3 cycles: O_stall_pc high same cycles, count reaches 2, O_instr held stable; after release sequence continues with no gaps in PC values and none repeated.
- FIFO full (count=2) plus I_branch with target 0x0100: next cycle O_valid=0; 0x0100 issued that cycle; O_valid with O_instr_pc=0x0100 two cycles later; discarded entries never appear.
- I_branch and I_stall same cycle with inflight_v=1: flush wins, O_stall_pc=0, in-flight word dropped.
- Branch to 0x3FFF then sequential: 0x3FFF issued and delivered, next PC 0x0000 delivered (wrap handled upstream, passed through).
- Assert I_rst asynchronously mid-stream between edges: O_valid, O_imem_en, O_stall_pc drop to 0 immediately; after release behaviour identical to first scenario.
